bcd_serial_adder: RTL and testbench
===================================

Name: bcd_serial_adder

Overview:
Parametrised N-digit BCD adder that processes one decimal digit per clock, least-significant digit first, using a single shared digit-adder with a registered carry. It is the sequential, width-generalised successor to the team's combinational 4-bit binary adders, and it backs the multi-digit decimal add path for display and counter logic. Operands are accepted and results returned over a ready/valid handshake.

Parameters:
DIGITS, 2, number of BCD digits per operand (>=1); operand width is 4*DIGITS bits.
CNT_W, $clog2(DIGITS+1), width of the internal digit counter; derived, do not override.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
start  input  1  request; accepted only when ready=1
A  input  4*DIGITS  BCD operand A, digit 0 in [3:0]
B  input  4*DIGITS  BCD operand B
Ci  input  1  decimal carry-in
sub  input  1  subtract request (see Optional Feature)
ready  output  1  high in IDLE
Sum  output  4*DIGITS  BCD result
Cout  output  1  decimal carry-out
err  output  1  some operand digit was >9
valid  output  1  result available
ack  input  1  consumer accepts result

Behaviour:
- Clock and reset: one clock domain, clk; reset_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset (reset_n=0 at a rising edge): state=IDLE, ready=1, valid=0, Sum=0, Cout=0, err=0, counter=0. Reset mid-operation abandons the operation with no partial result.
- FSM states are IDLE, RUN and DONE.
- IDLE: ready=1. On start=1:
  - latch A, B and Ci (Ci forced to 1 in subtract mode);
  - clear Sum, err and counter;
  - go to RUN.
- RUN: ready=0. Each cycle processes digit k=counter:
  - s = A[k] + B'[k] + c (5-bit);
  - if s>9, then digit = s+6 (low 4 bits) and c=1; otherwise digit = s and c=0;
  - Sum[k] is written; err |= (A[k]>9)|(B[k]>9), checked on raw B;
  - counter increments. After digit DIGITS-1 the FSM goes to DONE and Cout=c.
- DONE: valid=1, ready=0. Sum, Cout and err are held stable until ack=1, then the FSM returns to IDLE (valid=0, ready=1 next cycle).
- Latency: start is accepted at edge T; valid rises after edge T+DIGITS. Throughput is one operation per DIGITS+2 cycles when ack is tied high.
- start while ready=0 is ignored, with no queuing. ack while valid=0 is ignored.
- start and ack in the same cycle in DONE: only ack acts; start must be reasserted once ready=1.
- Invalid digits do not abort the operation. The correction rule above is still applied, and the resulting Sum is undefined-in-meaning but deterministic.
- The shared digit adder is combinational; all outputs are registered.

Optional Feature:
Macro BCD_SUB_EN.
- Defined: when sub=1 at start, the subtrahend digits are replaced by B'[k]=9-B[k] (nine's complement) and Ci is forced to 1, so the operation computes A-B mod 10^DIGITS.
  - Cout=1 means no borrow (A>=B).
  - Cout=0 means borrow; Sum is then the ten's complement of the magnitude.
- Not defined: the sub port exists but is ignored (treated as 0), and B'[k]=B[k] always.

Decomposition:
- Package bcd_pkg:
  - typedef logic [3:0] bcd_digit_t;
  - typedef enum {IDLE, RUN, DONE} bcd_state_t;
  - constants BCD_MAX=4'd9 and BCD_CORR=4'd6.
- Sub-module bcd_digit_add: combinational, ports (a, b, ci, sum, co, bad). It performs one-digit add with decimal correction and invalid-digit detect, and is instantiated once inside bcd_serial_adder.

Test Plan:
All scenarios use DIGITS=2 with ack held high unless stated.
- A=0x45, B=0x38, Ci=0 -> Sum=0x83, Cout=0, err=0; valid 2 cycles after the start edge.
- A=0x99, B=0x01, Ci=0 -> Sum=0x00, Cout=1. A=0x99, B=0x99, Ci=1 -> Sum=0x99, Cout=1.
- A=0x4A, B=0x10 -> err=1, valid asserted, FSM returns to IDLE normally.
- Hold ack=0 for 5 cycles in DONE -> valid, Sum and Cout stable throughout. Pulse start during RUN -> ignored, with no second result.
- reset_n=0 during RUN digit 1 -> next cycle ready=1, valid=0, Sum=0; a new start then completes correctly.
- (BCD_SUB_EN) A=0x52, B=0x17, sub=1 -> Sum=0x35, Cout=1; A=0x17, B=0x52, sub=1 -> Sum=0x65, Cout=0. Without the macro, sub=1 yields the plain sum 0x69.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_state_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd6;

  // 4-bit wrap keeps invalid digits invalid: 9-d > 9 exactly when d > 9.
  function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Operand/result handshake bundle for bcd_serial_adder; master = producer/consumer, slave = adder.
interface bcd_serial_adder_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
);
  logic                  start;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic                  Ci;
  logic                  sub;
  logic                  ready;
  logic [4*DIGITS-1:0]   Sum;
  logic                  Cout;
  logic                  err;
  logic                  valid;
  logic                  ack;

  modport master (
    output start, A, B, Ci, sub, ack,
    input  ready, Sum, Cout, err, valid
  );

  modport slave (
    input  start, A, B, Ci, sub, ack,
    output ready, Sum, Cout, err, valid
  );
endinterface

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with decimal correction and invalid-digit detect (combinational).
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       ci,
  output bcd_digit_t sum,
  output logic       co,
  output logic       bad
);

  logic [4:0] s;

  always_comb begin
    s   = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    bad = (a > BCD_MAX) || (b > BCD_MAX);
    if (s > {1'b0, BCD_MAX}) begin
      sum = s[3:0] + BCD_CORR;
      co  = 1'b1;
    end else begin
      sum = s[3:0];
      co  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// N-digit BCD adder, one digit per clock LSD first, through a single shared digit adder.
// Define BCD_SUB_EN to enable nine's-complement subtraction via the sub input.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 2,
  localparam int CNT_W  = $clog2(DIGITS + 1)
)(
  input  logic              clk,
  input  logic              reset_n,
  bcd_serial_adder_if.slave bus
);

`ifdef BCD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  bcd_state_t          state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [4*DIGITS-1:0] a_reg, a_next;
  logic [4*DIGITS-1:0] b_reg, b_next;
  logic [4*DIGITS-1:0] sum_reg, sum_next;
  logic                sub_reg, sub_next;
  logic                carry_reg, carry_next;
  logic                cout_reg, cout_next;
  logic                err_reg, err_next;
  logic                ready_reg, valid_reg;
  logic                sub_eff;

  bcd_digit_t a_dig [DIGITS];
  bcd_digit_t b_dig [DIGITS];
  bcd_digit_t a_cur, b_cur, d_sum;
  logic       d_co, d_bad;

  assign sub_eff = SUB_EN & bus.sub;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
    assign a_dig[gi] = a_reg[4*gi +: 4];
    assign b_dig[gi] = sub_reg ? nines_comp(b_reg[4*gi +: 4]) : b_reg[4*gi +: 4];
  end

  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_reg == CNT_W'(i)) begin
        a_cur = a_dig[i];
        b_cur = b_dig[i];
      end
    end
  end

  bcd_digit_add u_digit (
    .a   (a_cur),
    .b   (b_cur),
    .ci  (carry_reg),
    .sum (d_sum),
    .co  (d_co),
    .bad (d_bad)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sub_next   = sub_reg;
    carry_next = carry_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          a_next     = bus.A;
          b_next     = bus.B;
          sub_next   = sub_eff;
          carry_next = bus.Ci | sub_eff;
          sum_next   = '0;
          cout_next  = 1'b0;
          err_next   = 1'b0;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (cnt_reg == CNT_W'(i)) sum_next[4*i +: 4] = d_sum;
        end
        carry_next = d_co;
        err_next   = err_reg | d_bad;
        cnt_next   = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(DIGITS - 1)) begin
          cout_next  = d_co;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      err_reg   <= 1'b0;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sub_reg   <= sub_next;
      carry_reg <= carry_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      err_reg   <= err_next;
      ready_reg <= (state_next == IDLE);
      valid_reg <= (state_next == DONE);
    end
  end

  assign bus.ready = ready_reg;
  assign bus.valid = valid_reg;
  assign bus.Sum   = sum_reg;
  assign bus.Cout  = cout_reg;
  assign bus.err   = err_reg;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=2): vector table, corner sequences, random vs decimal model.
module tb_bcd_serial_adder;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

`ifdef BCD_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } vec_t;

  localparam int NVEC = 10;
  vec_t tbl [NVEC];

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Decimal arithmetic for valid operands; digit-by-digit rule when any digit is out of range.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sb);
    bit           use_sub;
    bit           bad;
    int           va, vb, p, t, c, ad, bd;
    logic [W-1:0] s;
    logic         co;
    use_sub = SUB_ON && sb;
    bad = 1'b0;
    s   = '0;
    for (int k = 0; k < DIGITS; k++)
      if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) bad = 1'b1;
    if (!bad) begin
      va = 0; vb = 0; p = 1;
      for (int k = 0; k < DIGITS; k++) begin
        va = va + int'(a[4*k +: 4]) * p;
        vb = vb + int'(b[4*k +: 4]) * p;
        p  = p * 10;
      end
      t  = use_sub ? (va + (p - 1 - vb) + 1) : (va + vb + int'(ci));
      co = (t >= p);
      t  = t % p;
      for (int k = 0; k < DIGITS; k++) begin
        s[4*k +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end else begin
      c = use_sub ? 1 : int'(ci);
      for (int k = 0; k < DIGITS; k++) begin
        ad = int'(a[4*k +: 4]);
        bd = int'(b[4*k +: 4]);
        if (use_sub) bd = (9 - bd) & 15;
        t = ad + bd + c;
        if (t > 9) begin
          t = (t + 6) & 15;
          c = 1;
        end else begin
          c = 0;
        end
        s[4*k +: 4] = 4'(t);
      end
      co = (c != 0);
    end
    return {bad, co, s};
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb, input int hold,
                        input logic [W-1:0] exp_s, input logic exp_co, input logic exp_er);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
    bus.A = a; bus.B = b; bus.Ci = ci; bus.sub = sb; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(DIGITS));
    chk({tag, "_sum"},  32'(bus.Sum),  32'(exp_s));
    chk({tag, "_cout"}, 32'(bus.Cout), 32'(exp_co));
    chk({tag, "_err"},  32'(bus.err),  32'(exp_er));
    $display("op %s A=%h B=%h Ci=%b sub=%b -> Sum=%h Cout=%b err=%b (exp %h %b %b)",
             tag, a, b, ci, sb, bus.Sum, bus.Cout, bus.err, exp_s, exp_co, exp_er);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(bus.valid), 32'd1);
      chk({tag, "_hold_sum"},   32'(bus.Sum),   32'(exp_s));
      chk({tag, "_hold_cout"},  32'(bus.Cout),  32'(exp_co));
    end
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    chk({tag, "_idle"}, 32'({bus.valid, bus.ready}), 32'b01);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rci, rsb;
    logic [W+1:0] m;
    int           n;

    reset_n = 1'b0;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Ci = 1'b0; bus.sub = 1'b0; bus.ack = 1'b0;

    tbl[0] = '{8'h45, 8'h38, 1'b0, 1'b0, 8'h83, 1'b0, 1'b0};
    tbl[1] = '{8'h99, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h99, 8'h99, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0};
    tbl[3] = '{8'h4A, 8'h10, 1'b0, 1'b0, 8'h60, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{8'h09, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
    tbl[6] = '{8'h50, 8'h50, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{8'h12, 8'hC3, 1'b0, 1'b0, 8'h35, 1'b1, 1'b1};
`ifdef BCD_SUB_EN
    tbl[8] = '{8'h52, 8'h17, 1'b0, 1'b1, 8'h35, 1'b1, 1'b0};
    tbl[9] = '{8'h17, 8'h52, 1'b0, 1'b1, 8'h65, 1'b0, 1'b0};
`else
    tbl[8] = '{8'h52, 8'h17, 1'b0, 1'b1, 8'h69, 1'b0, 1'b0};
    tbl[9] = '{8'h17, 8'h52, 1'b0, 1'b1, 8'h69, 1'b0, 1'b0};
`endif

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_sum",   32'(bus.Sum),   32'd0);
    chk("rst_cout",  32'(bus.Cout),  32'd0);
    chk("rst_err",   32'(bus.err),   32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sb, 0,
             tbl[i].sum, tbl[i].cout, tbl[i].err);

    // Result must stay frozen while the consumer stalls.
    run_op("hold", 8'h27, 8'h68, 1'b0, 1'b0, 5, 8'h95, 1'b0, 1'b0);

    // A start pulse while busy must be dropped, not queued.
    bus.A = 8'h12; bus.B = 8'h34; bus.Ci = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.A = 8'h77; bus.B = 8'h11; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("busy_start_seen", 32'(bus.valid), 32'd1);
    chk("busy_start_sum",  32'(bus.Sum),   32'h46);
    $display("op busy_start A=12 B=34 -> Sum=%h", bus.Sum);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("busy_start_no_second", 32'({bus.valid, bus.ready}), 32'b01);
      @(negedge clk);
    end

    // Reset while the second digit is being processed.
    bus.A = 8'h45; bus.B = 8'h38; bus.Ci = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.ready), 32'd1);
    chk("midrst_valid", 32'(bus.valid), 32'd0);
    chk("midrst_sum",   32'(bus.Sum),   32'd0);
    $display("op midrun_reset ready=%b valid=%b Sum=%h", bus.ready, bus.valid, bus.Sum);
    reset_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", 8'h27, 8'h15, 1'b0, 1'b0, 0, 8'h42, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < DIGITS; k++) begin
        ra[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
        rb[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      end
      rci = 1'($urandom_range(0, 1));
      rsb = 1'($urandom_range(0, 1));
      m = model(ra, rb, rci, rsb);
      run_op($sformatf("rnd%0d", i), ra, rb, rci, rsb, 0, m[W-1:0], m[W], m[W+1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
